// File: rtl/lif_spike_arbiter.sv
// Serialises per-timestep LIF spike vectors into a round-robin AER stream over valid/ready.
// Optional timestep tagging of events is enabled by defining SPIKE_TS_EN.
module lif_spike_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned AW    = $clog2(N),
    parameter int unsigned CNT_W = 8
`ifdef SPIKE_TS_EN
    ,
    parameter int unsigned TS_W  = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic [N-1:0]     spike_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    out_addr,
    output logic             busy,
    output logic             overflow,
`ifdef SPIKE_TS_EN
    output logic [TS_W-1:0]  out_ts,
`endif
    output logic [CNT_W-1:0] drop_cnt
);

    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     grant_vec, drop_vec, capture_vec;
    logic [AW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]    out_addr_q, out_addr_d;
    logic [AW-1:0]    grant_idx;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [AW:0]      n_drop;
    logic [CNT_W:0]   drop_sum;
    logic             free, grant_any, grant;
    int               idx;

    // Walk offsets from the far end so the nearest pending bit after rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int off = int'(N) - 1; off >= 0; off--) begin
            idx = (int'(rr_ptr_q) + off) % int'(N);
            if (pending_q[idx]) begin
                grant_any = 1'b1;
                grant_idx = AW'(idx);
            end
        end
    end

    always_comb begin
        free        = ~out_valid_q | out_ready;
        grant       = free & grant_any;
        grant_vec   = grant ? (N'(1) << grant_idx) : '0;
        capture_vec = {N{step}} & spike_in;
        // A bit granted this cycle frees its slot, so a new spike on it is not a drop.
        drop_vec    = capture_vec & pending_q & ~grant_vec;
        pending_d   = (pending_q & ~grant_vec) | capture_vec;

        n_drop = '0;
        for (int i = 0; i < int'(N); i++) begin
            n_drop = n_drop + (AW+1)'(drop_vec[i]);
        end
        drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(n_drop);
        drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        overflow_d = overflow_q | (|drop_vec);

        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        rr_ptr_d    = rr_ptr_q;
        if (grant) begin
            out_valid_d = 1'b1;
            out_addr_d  = grant_idx;
            rr_ptr_d    = (grant_idx == AW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end else if (free) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

`ifdef SPIKE_TS_EN
    logic [TS_W-1:0] ts_cnt_q, out_ts_q;

    // Tag carries the timestep count at grant time, not capture time.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_cnt_q <= '0;
            out_ts_q <= '0;
        end else begin
            if (step) ts_cnt_q <= ts_cnt_q + 1'b1;
            if (grant) out_ts_q <= ts_cnt_q;
        end
    end

    assign out_ts = out_ts_q;
`endif

    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;
    assign busy      = (|pending_q) | out_valid_q;

endmodule

// File: tb/tb_lif_spike_arbiter.sv
// Randomised and directed bench for lif_spike_arbiter against a cycle-level behavioural model.
// Timestamp checks are included when SPIKE_TS_EN is defined.
module tb_lif_spike_arbiter;

    localparam int N     = 4;
    localparam int AW    = 2;
    localparam int CNT_W = 8;
    localparam int TS_W  = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             step;
    logic [N-1:0]     spike_in;
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    out_addr;
    logic             busy;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;
`ifdef SPIKE_TS_EN
    logic [TS_W-1:0]  out_ts;
`endif

    always #5 clk = ~clk;

    lif_spike_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .spike_in  (spike_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .busy      (busy),
        .overflow  (overflow),
`ifdef SPIKE_TS_EN
        .out_ts    (out_ts),
`endif
        .drop_cnt  (drop_cnt)
    );

    // Reference model state
    int m_pend [N];
    int m_rr, m_valid, m_addr, m_ovf, m_drop, m_ts, m_ts_out;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int g, drops, any_free, idx;
        if (reset) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_rr = 0; m_valid = 0; m_addr = 0; m_ovf = 0; m_drop = 0; m_ts = 0; m_ts_out = 0;
            return;
        end
        any_free = (m_valid == 0) || out_ready;
        g = -1;
        if (any_free) begin
            for (int off = 0; off < N; off++) begin
                idx = (m_rr + off) % N;
                if (g < 0 && m_pend[idx] != 0) g = idx;
            end
        end
        drops = 0;
        for (int i = 0; i < N; i++) begin
            if (step && spike_in[i] && m_pend[i] != 0 && i != g) drops++;
            m_pend[i] = ((m_pend[i] != 0 && i != g) || (step && spike_in[i])) ? 1 : 0;
        end
        if (g >= 0) begin
            m_valid = 1; m_addr = g; m_rr = (g + 1) % N; m_ts_out = m_ts;
        end else if (any_free) begin
            m_valid = 0;
        end
        if (step) m_ts = (m_ts + 1) % (1 << TS_W);
        m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
        if (drops > 0) m_ovf = 1;
    endtask

    task automatic compare_all();
        int any_pend;
        any_pend = 0;
        foreach (m_pend[i]) if (m_pend[i] != 0) any_pend = 1;
        check_eq("out_valid", out_valid, m_valid);
        check_eq("out_addr", out_addr, m_addr);
        check_eq("busy", busy, (any_pend != 0 || m_valid != 0) ? 1 : 0);
        check_eq("overflow", overflow, m_ovf);
        check_eq("drop_cnt", drop_cnt, m_drop);
`ifdef SPIKE_TS_EN
        check_eq("out_ts", out_ts, m_ts_out);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic r, input logic s, input logic [N-1:0] sp, input logic rdy);
        reset = r; step = s; spike_in = sp; out_ready = rdy;
    endtask

    initial begin
        drive(1'b1, 1'b0, '0, 1'b1);
        tick();
        tick();

        // Reset mid-burst with pending full, output busy and overflow set
        drive(1'b0, 1'b1, 4'b1111, 1'b0);
        tick();
        tick();
        tick();
        check_eq("pre_rst_ovf", overflow, 1);
        drive(1'b1, 1'b0, '0, 1'b0);
        tick();
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_drop", drop_cnt, 0);

        // 1011 with ready: 0,1,3 back to back, first valid two edges after step
        drive(1'b0, 1'b1, 4'b1011, 1'b1);
        tick();
        check_eq("lat_not_yet", out_valid, 0);
        drive(1'b0, 1'b0, '0, 1'b1);
        tick(); check_eq("seq_a0", out_addr, 0); check_eq("seq_v0", out_valid, 1);
        tick(); check_eq("seq_a1", out_addr, 1);
        tick(); check_eq("seq_a3", out_addr, 3); check_eq("seq_busy", busy, 1);
        tick(); check_eq("seq_idle_v", out_valid, 0); check_eq("seq_idle_busy", busy, 0);

        // Back-pressure: address must hold while ready is low
        drive(1'b0, 1'b1, 4'b1011, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("stall_v", out_valid, 1);
            check_eq("stall_a", out_addr, 0);
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        tick(); check_eq("drain_a1", out_addr, 1);
        tick(); check_eq("drain_a3", out_addr, 3);
        tick(); check_eq("drain_idle", out_valid, 0);

        // Overflow only when a pending bit that is not being granted is hit again
        drive(1'b0, 1'b1, 4'b0001, 1'b0);
        tick();
        drive(1'b0, 1'b1, 4'b0011, 1'b0);
        tick();
        check_eq("ovf_none", overflow, 0);
        drive(1'b0, 1'b1, 4'b0001, 1'b0);
        tick();
        check_eq("ovf_set", overflow, 1);
        check_eq("ovf_cnt", drop_cnt, 1);
        drive(1'b0, 1'b0, '0, 1'b1);
        repeat (4) tick();

        // Fairness: with 3 held in output, pending 1001 drains 0 then 3
        drive(1'b0, 1'b1, 4'b1000, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        tick();
        check_eq("rr_hold3", out_addr, 3);
        drive(1'b0, 1'b1, 4'b1001, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        tick(); check_eq("rr_wrap0", out_addr, 0);
        tick(); check_eq("rr_then3", out_addr, 3);
        tick();

        // Saturating drop counter
        drive(1'b0, 1'b1, 4'b1111, 1'b0);
        repeat (70) tick();
        check_eq("drop_sat", drop_cnt, 255);

`ifdef SPIKE_TS_EN
        drive(1'b1, 1'b0, '0, 1'b1);
        tick();
        drive(1'b0, 1'b1, 4'b0100, 1'b1);
        tick();
        tick(); check_eq("ts1", out_ts, 1); check_eq("ts_a1", out_addr, 2);
        tick(); check_eq("ts2", out_ts, 2);
        drive(1'b0, 1'b0, '0, 1'b1);
        tick(); check_eq("ts3", out_ts, 3); check_eq("ts_a3", out_addr, 2);
`endif

        // Random traffic with occasional resets
        drive(1'b1, 1'b0, '0, 1'b1);
        tick();
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                  N'($urandom),
                  ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
